// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state encoding and pixel constants for the Sobel frame path
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sobel_state_t;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

    localparam int DEF_ROW    = 180;
    localparam int DEF_COLUMN = 180;

endpackage

// File: rtl/sobel_drain_timer.sv
// rtl/sobel_drain_timer.sv - load/clear/increment counter with terminal-count flag
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      force count to 0 (highest priority)
//   load       load count from load_val
//   load_val   value for load
//   inc        increment count, saturating at LIMIT
//   tc         count is LIMIT-1: the next increment reaches LIMIT
module sobel_drain_timer #(
    parameter int LIMIT = 4096,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame sequencer gating pixels into the Sobel engine and counting results
//
// Ports:
//   sys_clk, sys_rst               clock, synchronous active-high reset
//   start                          1-cycle pulse, starts a frame from IDLE/DONE
//   pix_in, pix_valid              incoming gray pixel stream
//   sobel_data_in, sobel_in_flag   pixel forwarded to the Sobel engine (1-cycle latency)
//   sobel_data_out, sobel_out_flag result from the Sobel engine
//   res_data, res_valid            registered result forwarded downstream
//   busy                           frame in LOAD or DRAIN
//   frame_done                     1-cycle pulse on successful frame end
//   err_timeout                    sticky drain timeout flag
//   in_cnt, out_cnt                pixels forwarded / results received this frame
//   edge_cnt                       white results this frame (only with SOBEL_CTRL_STATS_EN)
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int ROW           = DEF_ROW,
    parameter int COLUMN        = DEF_COLUMN,
    parameter int OUT_PIXELS    = (ROW - 2) * (COLUMN - 2),
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int CNT_W         = 15
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    output logic [7:0]       sobel_data_in,
    output logic             sobel_in_flag,
    input  logic [7:0]       sobel_data_out,
    input  logic             sobel_out_flag,
    output logic [7:0]       res_data,
    output logic             res_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] in_cnt,
`ifdef SOBEL_CTRL_STATS_EN
    output logic [CNT_W-1:0] out_cnt,
    output logic [CNT_W-1:0] edge_cnt
`else
    output logic [CNT_W-1:0] out_cnt
`endif
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(ROW * COLUMN - 1);
    localparam logic [CNT_W-1:0] OUT_FULL   = CNT_W'(OUT_PIXELS);

    sobel_state_t     state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [7:0]       data_in_q, data_in_d, res_data_q, res_data_d;
    logic             in_flag_q, in_flag_d, res_valid_q, res_valid_d;
    logic             frame_done_q, frame_done_d, err_q, err_d;
    logic             timer_clear, timer_inc, timer_tc, accept_res;
`ifdef SOBEL_CTRL_STATS_EN
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
`endif

    sobel_drain_timer #(.LIMIT(DRAIN_TIMEOUT)) u_drain_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .clear    (timer_clear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (timer_inc),
        .tc       (timer_tc)
    );

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        data_in_d    = data_in_q;
        res_data_d   = res_data_q;
        err_d        = err_q;
        in_flag_d    = 1'b0;
        res_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        timer_clear  = 1'b1;
        timer_inc    = 1'b0;
`ifdef SOBEL_CTRL_STATS_EN
        edge_cnt_d   = edge_cnt_q;
`endif

        // Result path runs independently of pixel forwarding so both can
        // be serviced in the same cycle.
        accept_res = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && sobel_out_flag;
        if (accept_res) begin
            res_valid_d = 1'b1;
            res_data_d  = sobel_data_out;
            if (out_cnt_q != OUT_FULL) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
`ifdef SOBEL_CTRL_STATS_EN
            if (sobel_data_out == WHITE) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
`endif
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
`ifdef SOBEL_CTRL_STATS_EN
                    edge_cnt_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (pix_valid) begin
                    in_flag_d = 1'b1;
                    data_in_d = pix_in;
                    in_cnt_d  = in_cnt_q + 1'b1;
                    if (in_cnt_q == FRAME_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                timer_clear = sobel_out_flag;
                timer_inc   = !sobel_out_flag;
                // Completion uses the post-increment count so frame_done
                // lines up with the last res_valid.
                if (out_cnt_d == OUT_FULL) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end else if (timer_inc && timer_tc) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            data_in_q    <= BLACK;
            res_data_q   <= BLACK;
            in_flag_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef SOBEL_CTRL_STATS_EN
            edge_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            data_in_q    <= data_in_d;
            res_data_q   <= res_data_d;
            in_flag_q    <= in_flag_d;
            res_valid_q  <= res_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef SOBEL_CTRL_STATS_EN
            edge_cnt_q   <= edge_cnt_d;
`endif
        end
    end

    assign sobel_data_in = data_in_q;
    assign sobel_in_flag = in_flag_q;
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign frame_done    = frame_done_q;
    assign err_timeout   = err_q;
    assign in_cnt        = in_cnt_q;
    assign out_cnt       = out_cnt_q;
`ifdef SOBEL_CTRL_STATS_EN
    assign edge_cnt      = edge_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - self-checking bench for sobel_frame_ctrl (small frame geometry)
module tb_sobel_frame_ctrl;

    localparam int ROW    = 5;
    localparam int COLUMN = 6;
    localparam int FRAME  = ROW * COLUMN;
    localparam int OUT    = (ROW - 2) * (COLUMN - 2);
    localparam int TMO    = 40;
    localparam int CNT_W  = 15;

    logic             sys_clk = 1'b0;
    logic             sys_rst, start, pix_valid, sobel_out_flag;
    logic [7:0]       pix_in, sobel_data_out, sobel_data_in, res_data;
    logic             sobel_in_flag, res_valid, busy, frame_done, err_timeout;
    logic [CNT_W-1:0] in_cnt, out_cnt;
`ifdef SOBEL_CTRL_STATS_EN
    logic [CNT_W-1:0] edge_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    sobel_frame_ctrl #(
        .ROW(ROW), .COLUMN(COLUMN), .DRAIN_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .start          (start),
        .pix_in         (pix_in),
        .pix_valid      (pix_valid),
        .sobel_data_in  (sobel_data_in),
        .sobel_in_flag  (sobel_in_flag),
        .sobel_data_out (sobel_data_out),
        .sobel_out_flag (sobel_out_flag),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_timeout    (err_timeout),
        .in_cnt         (in_cnt),
`ifdef SOBEL_CTRL_STATS_EN
        .out_cnt        (out_cnt),
        .edge_cnt       (edge_cnt)
`else
        .out_cnt        (out_cnt)
`endif
    );

    // Reference model: a frame is "active" from start until it completes
    // or times out; it is loading while fewer than FRAME pixels were taken.
    bit         m_active, m_err;
    int         m_in, m_out, m_idle, m_edges;
    bit         e_in_flag, e_res_valid, e_done;
    logic [7:0] e_data_in, e_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_err = 0; m_in = 0; m_out = 0; m_idle = 0; m_edges = 0;
        e_in_flag = 0; e_res_valid = 0; e_done = 0; e_data_in = 8'h00; e_res = 8'h00;
    endtask

    task automatic model_step(input bit st, input bit pv, input logic [7:0] px,
                              input bit of, input logic [7:0] od);
        bit loading;
        e_in_flag = 0; e_res_valid = 0; e_done = 0;
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_in = 0; m_out = 0; m_err = 0; m_idle = 0; m_edges = 0;
            end
        end else begin
            loading = (m_in < FRAME);
            if (loading && pv) begin
                e_in_flag = 1; e_data_in = px; m_in++;
            end
            if (of) begin
                e_res_valid = 1; e_res = od;
                if (m_out < OUT) m_out++;
                if (od == 8'hFF) m_edges++;
            end
            if (!loading) begin
                if (m_out == OUT) begin
                    e_done = 1; m_active = 0;
                end else if (of) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_err = 1; m_active = 0;
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit st, input bit pv, input logic [7:0] px,
                        input bit of, input logic [7:0] od);
        start = st; pix_valid = pv; pix_in = px; sobel_out_flag = of; sobel_data_out = od;
        model_step(st, pv, px, of, od);
        @(posedge sys_clk);
        @(negedge sys_clk);
        start = 0; pix_valid = 0; sobel_out_flag = 0;
    endtask

    task automatic check_model();
        chk("in_flag", sobel_in_flag, e_in_flag);
        chk("data_in", sobel_data_in, e_data_in);
        chk("res_valid", res_valid, e_res_valid);
        chk("res_data", res_data, e_res);
        chk("frame_done", frame_done, e_done);
        chk("busy", busy, m_active);
        chk("err_timeout", err_timeout, m_err);
        chk("in_cnt", in_cnt, m_in);
        chk("out_cnt", out_cnt, m_out);
`ifdef SOBEL_CTRL_STATS_EN
        chk("edge_cnt", edge_cnt, m_edges);
`endif
    endtask

    task automatic do_reset();
        sys_rst = 1; start = 0; pix_valid = 0; sobel_out_flag = 0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        model_reset();
        chk("rst_in_flag", sobel_in_flag, 0);
        chk("rst_data_in", sobel_data_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_in_cnt", in_cnt, 0);
        chk("rst_out_cnt", out_cnt, 0);
        sys_rst = 0;
    endtask

    task automatic rstep(input bit allow_of);
        bit         st = ($urandom_range(63) == 0);
        bit         pv = ($urandom_range(2) == 0);
        bit         of = allow_of && ($urandom_range(2) == 0);
        logic [7:0] px = 8'($urandom);
        logic [7:0] od;
        case ($urandom_range(2))
            0:       od = 8'h00;
            1:       od = 8'hFF;
            default: od = 8'($urandom);
        endcase
        step(st, pv, px, of, od);
        check_model();
    endtask

    typedef struct {
        bit st; bit pv; logic [7:0] px; bit of; logic [7:0] od;
        bit flag; logic [7:0] din; bit rv; logic [7:0] res; bit bsy; int icnt; int ocnt;
    } vec_t;

    function automatic vec_t mk(bit st, bit pv, logic [7:0] px, bit of, logic [7:0] od,
                                bit flag, logic [7:0] din, bit rv, logic [7:0] res,
                                bit bsy, int icnt, int ocnt);
        vec_t v;
        v.st = st; v.pv = pv; v.px = px; v.of = of; v.od = od;
        v.flag = flag; v.din = din; v.rv = rv; v.res = res; v.bsy = bsy;
        v.icnt = icnt; v.ocnt = ocnt;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   n_fwd, n_done;

        //            st pv px     of od     flag din    rv res    bsy in out
        tbl[0] = mk(0, 1, 8'hAA, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0); // idle: pixel dropped
        tbl[1] = mk(1, 1, 8'hBB, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0); // start, pixel dropped
        tbl[2] = mk(0, 1, 8'h11, 0, 8'h00, 1, 8'h11, 0, 8'h00, 1, 1, 0);
        tbl[3] = mk(0, 0, 8'h99, 0, 8'h00, 0, 8'h11, 0, 8'h00, 1, 1, 0); // data_in holds
        tbl[4] = mk(0, 1, 8'h22, 1, 8'hFF, 1, 8'h22, 1, 8'hFF, 1, 2, 1); // both serviced
        tbl[5] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h22, 0, 8'hFF, 1, 2, 1); // start while busy
        tbl[6] = mk(0, 0, 8'h00, 1, 8'h00, 0, 8'h22, 1, 8'h00, 1, 2, 2);
        tbl[7] = mk(0, 1, 8'h33, 1, 8'h5A, 1, 8'h33, 1, 8'h5A, 1, 3, 3);

        sys_rst = 1; start = 0; pix_valid = 0; pix_in = 0; sobel_out_flag = 0; sobel_data_out = 0;
        @(negedge sys_clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].st, tbl[i].pv, tbl[i].px, tbl[i].of, tbl[i].od);
            chk($sformatf("tbl%0d_flag", i), sobel_in_flag, tbl[i].flag);
            chk($sformatf("tbl%0d_din", i), sobel_data_in, tbl[i].din);
            chk($sformatf("tbl%0d_rv", i), res_valid, tbl[i].rv);
            chk($sformatf("tbl%0d_res", i), res_data, tbl[i].res);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_in_cnt", i), in_cnt, tbl[i].icnt);
            chk($sformatf("tbl%0d_out_cnt", i), out_cnt, tbl[i].ocnt);
        end
        for (int c = 0; c < 800 && m_active; c++) rstep(1);
        chk("tbl_frame_end", busy, 0);

        // Reset in the middle of LOAD aborts the frame without frame_done.
        step(1, 0, 8'h00, 0, 8'h00);
        check_model();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'(i + 1), 0, 8'h00);
            check_model();
        end
        do_reset();

        // Full frame with spaced pixels, one extra byte, then all results.
        n_fwd = 0;
        step(1, 0, 8'h00, 0, 8'h00);
        check_model();
        for (int i = 0; i <= FRAME; i++) begin
            step(0, 1, 8'(i * 7 + 3), 0, 8'h00);
            check_model();
            n_fwd += int'(sobel_in_flag);
            for (int g = 0; g < 2; g++) begin
                step(0, 0, 8'h00, 0, 8'h00);
                check_model();
                n_fwd += int'(sobel_in_flag);
            end
        end
        chk("fwd_pulses", n_fwd, FRAME);
        chk("in_cnt_full", in_cnt, FRAME);
        n_done = 0;
        for (int i = 0; i < OUT; i++) begin
            step(0, 0, 8'h00, 1, (i % 3 == 0) ? 8'hFF : 8'h00);
            check_model();
            if (i == OUT - 1) begin
                chk("done_on_last", frame_done, 1);
                chk("rv_on_last", res_valid, 1);
`ifdef SOBEL_CTRL_STATS_EN
                chk("edge_at_done", edge_cnt, (OUT + 2) / 3);
`endif
            end else begin
                n_done += int'(frame_done);
            end
        end
        chk("early_done", n_done, 0);
        step(0, 0, 8'h00, 0, 8'h00);
        check_model();
        chk("busy_after_done", busy, 0);
        chk("done_single", frame_done, 0);

        // Drain timeout after a few results.
        n_done = 0;
        step(1, 0, 8'h00, 0, 8'h00);
        check_model();
        chk("start_clears_out", out_cnt, 0);
        for (int i = 0; i < FRAME; i++) begin
            step(0, 1, 8'(i), 0, 8'h00);
            check_model();
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1, 8'h80);
            check_model();
        end
        for (int c = 0; c < TMO + 10 && busy; c++) begin
            step(0, 0, 8'h00, 0, 8'h00);
            check_model();
            n_done += int'(frame_done);
        end
        chk("tmo_err", err_timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_no_done", n_done, 0);
        chk("tmo_out_cnt", out_cnt, 5);
        step(1, 0, 8'h00, 0, 8'h00);
        check_model();
        chk("start_clears_err", err_timeout, 0);
        for (int c = 0; c < 800 && m_active; c++) rstep(1);

        // Random frames; every fourth one stalls its results to force a timeout.
        for (int f = 0; f < 16; f++) begin
            step(1, 0, 8'h00, 0, 8'h00);
            check_model();
            for (int c = 0; c < 800 && m_active; c++) begin
                rstep(!((f % 4 == 3) && (m_out >= OUT / 2)));
            end
            chk("rand_frame_end", busy, 0);
            if (f % 4 == 3) chk("rand_tmo_err", err_timeout, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer in front of sobel_algorithm. Accepts a byte stream of gray pixels from the UART receive path and gates exactly ROW*COLUMN pixels per frame into the Sobel engine via data_in/in_flag. Counts Sobel result pixels, forwards them downstream, and reports frame completion or timeout. Software or a top-level FSM pulses start once per frame.

Parameters:
ROW, 180, image height in pixels
COLUMN, 180, image width in pixels
OUT_PIXELS, (ROW-2)*(COLUMN-2) = 31684, Sobel outputs expected per frame (3x3 window, no border)
DRAIN_TIMEOUT, 4096, max idle cycles in DRAIN between consecutive sobel_out_flag pulses
CNT_W, 15, width of pixel counters (must hold ROW*COLUMN)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; begins a frame when IDLE or DONE
pix_in  in  8  gray pixel from UART rx
pix_valid  in  1  pix_in valid, 1-cycle pulse per byte
sobel_data_in  out  8  to sobel_algorithm data_in
sobel_in_flag  out  1  to sobel_algorithm in_flag
sobel_data_out  in  8  from sobel_algorithm data_out
sobel_out_flag  in  1  from sobel_algorithm out_flag
res_data  out  8  registered Sobel result (black/white)
res_valid  out  1  res_data qualifier
busy  out  1  high in LOAD or DRAIN
frame_done  out  1  1-cycle pulse on successful frame end
err_timeout  out  1  sticky; set on DRAIN timeout, cleared by start or reset
in_cnt  out  CNT_W  pixels forwarded this frame
out_cnt  out  CNT_W  results received this frame

Behaviour:
- Reset (sys_rst=1 at posedge): state IDLE; all outputs 0; counters 0; timeout counter 0. Reset mid-frame aborts without a frame_done pulse.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE/DONE: start -> LOAD; clear in_cnt, out_cnt, err_timeout. pix_valid ignored (not forwarded).
- LOAD: each pix_valid -> next cycle sobel_data_in=pix_in, sobel_in_flag=1 for exactly 1 cycle; in_cnt+1. Latency 1 cycle. When the pixel that makes in_cnt==ROW*COLUMN is forwarded -> DRAIN on the same edge. Extra bytes after that are dropped.
- sobel_in_flag is 0 whenever no pixel is forwarded; sobel_data_in holds its last value.
- Result path (LOAD and DRAIN): sobel_out_flag -> next cycle res_data=sobel_data_out, res_valid=1 for 1 cycle; out_cnt+1, saturating at OUT_PIXELS. Results in IDLE/DONE are dropped.
- DRAIN: out_cnt reaching OUT_PIXELS -> DONE with a frame_done pulse in the same cycle the last res_valid is asserted. Timeout counter resets on every sobel_out_flag and increments otherwise; reaching DRAIN_TIMEOUT -> set err_timeout, go to DONE, no frame_done.
- Simultaneous pix_valid and sobel_out_flag are both serviced in the same cycle.
- start while busy is ignored.
- busy=1 iff state in {LOAD, DRAIN}.

Optional Feature:
Macro SOBEL_CTRL_STATS_EN. Defined: adds output edge_cnt [CNT_W-1:0], which counts res_valid cycles with res_data==8'hFF, clears on start, and holds after DONE. Not defined: port and logic absent; all other behaviour is identical.

Decomposition:
- Shared package sobel_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, DONE=2'd3), BLACK=8'h00, WHITE=8'hFF, default ROW/COLUMN.
- One sub-module: sobel_drain_timer (load/clear/increment counter with terminal-count flag), reusable by the UART path.

Test Plan:
- Reset mid-LOAD after 100 pixels -> all outputs 0, state IDLE; a following start with 32400 pixels completes normally.
- start, then 32400 pix_valid pulses spaced 52 clocks -> 32400 sobel_in_flag pulses each 1 cycle after the stimulus, in_cnt=32400; byte 32401 not forwarded.
- Model 31684 sobel_out_flag pulses -> 31684 res_valid, out_cnt=31684, frame_done once, coincident with the last res_valid; busy falls the next cycle.
- Stop sobel_out_flag at out_cnt=20000 -> err_timeout=1 after 4096 cycles, no frame_done, state DONE; the next start clears err_timeout.
- start pulsed during LOAD -> ignored, counters not cleared; pix_valid and sobel_out_flag in the same cycle -> both counters increment.
- With SOBEL_CTRL_STATS_EN: 500 results of 8'hFF and the rest 8'h00 -> edge_cnt=500 at frame_done.
